// File: rtl/sci_serial_peer_if.sv
// Signal bundle between the SCI serial peer and whatever drives it (host model or bench).
// The slave modport is the peer's view; master is the driving side.
interface sci_serial_peer_if;
  logic       ce;
  logic       baud16_ce;
  logic       pe;
  logic       oe;
  logic       stop;
  logic       rxd_in;
  logic       txd_out;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_per;
  logic       rx_fer;
  logic       rx_orer;

  modport slave (
    input  ce, baud16_ce, pe, oe, stop, rxd_in, tx_data, tx_valid, rx_ack,
    output txd_out, tx_ready, tx_busy, rx_data, rx_valid, rx_per, rx_fer, rx_orer
  );

  modport master (
    output ce, baud16_ce, pe, oe, stop, rxd_in, tx_data, tx_valid, rx_ack,
    input  txd_out, tx_ready, tx_busy, rx_data, rx_valid, rx_per, rx_fer, rx_orer
  );
endinterface

// File: rtl/sci_serial_peer.sv
// Async-mode serial endpoint facing an SH7604 SCI: independent 16x-oversampled
// transmitter (with one-byte holding register) and receiver with error flags.
module sci_serial_peer #(
  parameter int OVS = 16
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  sci_serial_peer_if.slave io_bus
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT} rx_state_t;

  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic w_tick;
  assign w_tick = io_bus.ce & io_bus.baud16_ce;

  tx_state_t      r_tx_state;
  logic [CW-1:0]  r_tx_cnt;
  logic [2:0]     r_tx_bit;
  logic [7:0]     r_hold;
  logic [7:0]     r_tx_shift;
  logic           r_tx_ready;
  logic           r_tx_busy;
  logic           r_txd;
  logic           r_tx_pe;
  logic           r_tx_stop2;
  logic           r_tx_second;
  logic           r_tx_par;

  logic w_tx_bnd;
  logic w_tx_stop_end;
  logic w_tx_go;

  // r_tx_cnt holds the index of the next tick within the bit, so zero marks a bit boundary
  assign w_tx_bnd      = (r_tx_cnt == '0);
  assign w_tx_stop_end = (r_tx_state == TX_STOP) && w_tx_bnd && (!r_tx_stop2 || r_tx_second);
  assign w_tx_go       = w_tick && !r_tx_ready && ((r_tx_state == TX_IDLE) || w_tx_stop_end);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_ready  <= 1'b1;
      r_tx_busy   <= 1'b0;
      r_txd       <= 1'b1;
      r_tx_pe     <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx_second <= 1'b0;
      r_tx_par    <= 1'b0;
    end else if (io_bus.ce) begin
      if (io_bus.tx_valid && r_tx_ready) begin
        r_hold     <= io_bus.tx_data;
        r_tx_ready <= 1'b0;
      end
      if (w_tx_go) begin
        r_tx_state  <= TX_START;
        r_txd       <= 1'b0;
        r_tx_shift  <= r_hold;
        r_tx_ready  <= 1'b1;
        r_tx_busy   <= 1'b1;
        r_tx_cnt    <= CW'(1);
        r_tx_pe     <= io_bus.pe;
        r_tx_stop2  <= io_bus.stop;
        r_tx_par    <= parity_bit(r_hold, io_bus.oe);
        r_tx_second <= 1'b0;
      end else if (w_tick && (r_tx_state != TX_IDLE)) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
        if (w_tx_bnd) begin
          case (r_tx_state)
            TX_START: begin
              r_tx_state <= TX_DATA;
              r_txd      <= r_tx_shift[0];
              r_tx_bit   <= '0;
            end
            TX_DATA: begin
              if (r_tx_bit == 3'd7) begin
                r_tx_state  <= r_tx_pe ? TX_PAR : TX_STOP;
                r_txd       <= r_tx_pe ? r_tx_par : 1'b1;
                r_tx_second <= 1'b0;
              end else begin
                r_tx_bit   <= r_tx_bit + 1'b1;
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_txd      <= r_tx_shift[1];
              end
            end
            TX_PAR: begin
              r_tx_state <= TX_STOP;
              r_txd      <= 1'b1;
            end
            TX_STOP: begin
              if (w_tx_stop_end) begin
                r_tx_state <= TX_IDLE;
                r_tx_busy  <= 1'b0;
                r_txd      <= 1'b1;
              end else begin
                r_tx_second <= 1'b1;
              end
            end
            default: r_tx_state <= TX_IDLE;
          endcase
        end
      end
    end
  end

  rx_state_t      r_rx_state;
  logic [CW-1:0]  r_rx_cnt;
  logic [2:0]     r_rx_bit;
  logic [7:0]     r_rx_shift;
  logic           r_rxd_p0;
  logic           r_rxd_p1;
  logic           r_rx_pe;
  logic           r_rx_oe;
  logic           r_rx_perr;
  logic [7:0]     r_rx_data;
  logic           r_rx_valid;
  logic           r_rx_per;
  logic           r_rx_fer;
  logic           r_rx_orer;

  logic w_rxd;
  logic w_rx_smp;
  logic w_rx_load;
  logic w_rx_take;

  assign w_rxd     = r_rxd_p1;
  assign w_rx_smp  = w_tick && (r_rx_cnt == LAST);
  assign w_rx_load = (r_rx_state == RX_STOP) && w_rx_smp;
  assign w_rx_take = w_rx_load && (!r_rx_valid || io_bus.rx_ack);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rxd_p0   <= 1'b1;
      r_rxd_p1   <= 1'b1;
      r_rx_pe    <= 1'b0;
      r_rx_oe    <= 1'b0;
      r_rx_perr  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_per   <= 1'b0;
      r_rx_fer   <= 1'b0;
      r_rx_orer  <= 1'b0;
    end else if (io_bus.ce) begin
      // input synchronizer stage p0 -> p1
      r_rxd_p0 <= io_bus.rxd_in;
      r_rxd_p1 <= r_rxd_p0;
      if (w_rx_take) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        r_rx_per   <= r_rx_perr;
        r_rx_fer   <= !w_rxd;
        if (io_bus.rx_ack) r_rx_orer <= 1'b0;
      end else if (w_rx_load) begin
        r_rx_orer <= 1'b1;
      end else if (io_bus.rx_ack) begin
        r_rx_valid <= 1'b0;
        r_rx_orer  <= 1'b0;
      end
      if (w_tick) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!w_rxd) begin
              r_rx_state <= RX_START;
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
              r_rx_pe    <= io_bus.pe;
              r_rx_oe    <= io_bus.oe;
              r_rx_perr  <= 1'b0;
            end
          end
          RX_START: begin
            if (r_rx_cnt == MID) begin
              r_rx_state <= w_rxd ? RX_IDLE : RX_DATA;
              r_rx_cnt   <= '0;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          RX_DATA, RX_PAR, RX_STOP: begin
            r_rx_cnt <= w_rx_smp ? '0 : r_rx_cnt + 1'b1;
            if (w_rx_smp) begin
              if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
                if (r_rx_bit == 3'd7) r_rx_state <= r_rx_pe ? RX_PAR : RX_STOP;
              end else if (r_rx_state == RX_PAR) begin
                r_rx_perr  <= parity_bit(r_rx_shift, r_rx_oe) != w_rxd;
                r_rx_state <= RX_STOP;
              end else begin
                r_rx_state <= w_rxd ? RX_IDLE : RX_WAIT;
              end
            end
          end
          RX_WAIT: if (w_rxd) r_rx_state <= RX_IDLE;
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign io_bus.txd_out  = r_txd;
  assign io_bus.tx_ready = r_tx_ready;
  assign io_bus.tx_busy  = r_tx_busy;
  assign io_bus.rx_data  = r_rx_data;
  assign io_bus.rx_valid = r_rx_valid;
  assign io_bus.rx_per   = r_rx_per;
  assign io_bus.rx_fer   = r_rx_fer;
  assign io_bus.rx_orer  = r_rx_orer;
endmodule

// File: tb/tb_sci_serial_peer.sv
// Bench for sci_serial_peer: drives frames onto RXD, watches TXD, and checks
// results against scoreboard queues filled as stimulus is issued.
module tb_sci_serial_peer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   tick_no = 0;
  int   div = 0;

  typedef struct {
    logic [7:0] d;
    logic       per;
    logic       fer;
  } rx_exp_t;

  rx_exp_t rxq[$];
  logic    txq[$];

  sci_serial_peer_if bus();

  sci_serial_peer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.ce && bus.baud16_ce) tick_no++;

  initial begin
    bus.baud16_ce = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      div = (div + 1) % 3;
      bus.baud16_ce = (div == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic wait_until(input int t);
    while (tick_no < t) @(negedge clk);
  endtask

  task automatic wait_ticks(input int n);
    int t;
    t = tick_no + n;
    wait_until(t);
  endtask

  task automatic rx_bit(input logic b, input int n);
    bus.rxd_in = b;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip_par, input logic ack_at_load);
    int s;
    rx_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) rx_bit(d[i], 16);
    if (bus.pe) rx_bit((^d) ^ bus.oe ^ flip_par, 16);
    bus.rxd_in = 1'b1;
    s = tick_no;
    if (ack_at_load) begin
      wait_until(s + 8);
      while (!bus.baud16_ce) @(negedge clk);
      bus.rx_ack = 1'b1;
      @(negedge clk);
      bus.rx_ack = 1'b0;
    end
    wait_until(s + (bus.stop ? 32 : 16));
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!bus.rx_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = bus.rx_valid;
  endtask

  task automatic do_ack();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] d);
    int n;
    n = 0;
    while (!bus.tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_tx_start(output int n0, output bit ok);
    int n;
    n = 0;
    while (bus.txd_out !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.txd_out === 1'b0);
    n0 = tick_no;
  endtask

  task automatic push_tx_frame(input logic [7:0] d, input logic pe, input logic oe, input logic stop2);
    txq.push_back(1'b0);
    for (int i = 0; i < 8; i++) txq.push_back(d[i]);
    if (pe) txq.push_back((^d) ^ oe);
    txq.push_back(1'b1);
    if (stop2) txq.push_back(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total_cnt++; if (bus.txd_out !== 1'b1) $display("FAIL reset_txd: got %b want 1", bus.txd_out); else pass_cnt++;
    total_cnt++; if (bus.tx_ready !== 1'b1) $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready); else pass_cnt++;
    total_cnt++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); else pass_cnt++;
    total_cnt++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); else pass_cnt++;
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); else pass_cnt++;
    total_cnt++; if ({bus.rx_per, bus.rx_fer, bus.rx_orer} !== 3'b000) $display("FAIL reset_rx_flags: got %b want 000", {bus.rx_per, bus.rx_fer, bus.rx_orer}); else pass_cnt++;
  endtask

  task automatic test_rx_basic();
    int s;
    rx_exp_t e;
    bus.pe = 1'b0; bus.stop = 1'b0;
    rxq.push_back('{8'h3C, 1'b0, 1'b0});
    rx_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) rx_bit(i inside {2, 3, 4, 5}, 16);
    bus.rxd_in = 1'b1;
    s = tick_no;
    wait_until(s + 7);
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL rx_early_valid: got %b want 0", bus.rx_valid); else pass_cnt++;
    wait_until(s + 11);
    total_cnt++; if (bus.rx_valid !== 1'b1) $display("FAIL rx_stop_mid_valid: got %b want 1", bus.rx_valid); else pass_cnt++;
    wait_until(s + 16);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL rx_3c_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if ({bus.rx_per, bus.rx_fer} !== {e.per, e.fer}) $display("FAIL rx_3c_flags: got %b want %b", {bus.rx_per, bus.rx_fer}, {e.per, e.fer}); else pass_cnt++;
    do_ack();
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL rx_ack_clear: got %b want 0", bus.rx_valid); else pass_cnt++;
  endtask

  task automatic test_rx_parity();
    bit ok;
    rx_exp_t e;
    bus.pe = 1'b1; bus.oe = 1'b1;
    rxq.push_back('{8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_valid(ok);
    total_cnt++; if (!ok) $display("FAIL par_bad_valid: got 0 want 1"); else pass_cnt++;
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL par_bad_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if ({bus.rx_per, bus.rx_fer} !== {e.per, e.fer}) $display("FAIL par_bad_flags: got %b want %b", {bus.rx_per, bus.rx_fer}, {e.per, e.fer}); else pass_cnt++;
    do_ack();
    total_cnt++; if (bus.rx_per !== 1'b1) $display("FAIL par_persist: got %b want 1", bus.rx_per); else pass_cnt++;
    rxq.push_back('{8'h07, 1'b0, 1'b0});
    send_frame(8'h07, 1'b0, 1'b0);
    wait_valid(ok);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL par_good_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if (bus.rx_per !== e.per) $display("FAIL par_good_per: got %b want %b", bus.rx_per, e.per); else pass_cnt++;
    do_ack();
    bus.pe = 1'b0; bus.oe = 1'b0;
  endtask

  task automatic test_glitch();
    bit ok;
    rx_exp_t e;
    bus.rxd_in = 1'b0;
    wait_ticks(5);
    bus.rxd_in = 1'b1;
    wait_ticks(200);
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL glitch_no_frame: got %b want 0", bus.rx_valid); else pass_cnt++;
    rxq.push_back('{8'h96, 1'b0, 1'b0});
    send_frame(8'h96, 1'b0, 1'b0);
    wait_valid(ok);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL glitch_next_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_overrun();
    rx_exp_t e;
    rxq.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL ovr_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if ({bus.rx_valid, bus.rx_orer} !== 2'b11) $display("FAIL ovr_flags: got %b want 11", {bus.rx_valid, bus.rx_orer}); else pass_cnt++;
    bus.ce = 1'b0;
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
    bus.ce = 1'b1;
    @(negedge clk);
    total_cnt++; if ({bus.rx_valid, bus.rx_orer} !== 2'b11) $display("FAIL ovr_ack_no_ce: got %b want 11", {bus.rx_valid, bus.rx_orer}); else pass_cnt++;
    do_ack();
    total_cnt++; if ({bus.rx_valid, bus.rx_orer} !== 2'b00) $display("FAIL ovr_ack_clear: got %b want 00", {bus.rx_valid, bus.rx_orer}); else pass_cnt++;
  endtask

  task automatic test_ack_at_load();
    rx_exp_t e;
    rxq.push_back('{8'h11, 1'b0, 1'b0});
    send_frame(8'h11, 1'b0, 1'b0);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL ackld_first: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    rxq.push_back('{8'h22, 1'b0, 1'b0});
    send_frame(8'h22, 1'b0, 1'b1);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL ackld_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if ({bus.rx_valid, bus.rx_orer} !== 2'b10) $display("FAIL ackld_flags: got %b want 10", {bus.rx_valid, bus.rx_orer}); else pass_cnt++;
    do_ack();
  endtask

  task automatic test_break();
    int s;
    rx_exp_t e;
    rxq.push_back('{8'h00, 1'b0, 1'b1});
    bus.rxd_in = 1'b0;
    s = tick_no;
    wait_until(s + 200);
    total_cnt++; if (bus.rx_valid !== 1'b1) $display("FAIL brk_valid: got %b want 1", bus.rx_valid); else pass_cnt++;
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d) $display("FAIL brk_data: got %h want %h", bus.rx_data, e.d); else pass_cnt++;
    total_cnt++; if ({bus.rx_per, bus.rx_fer} !== {e.per, e.fer}) $display("FAIL brk_flags: got %b want %b", {bus.rx_per, bus.rx_fer}, {e.per, e.fer}); else pass_cnt++;
    do_ack();
    wait_until(s + 300);
    total_cnt++; if (bus.rx_valid !== 1'b0) $display("FAIL brk_held_second: got %b want 0", bus.rx_valid); else pass_cnt++;
    bus.rxd_in = 1'b1;
    wait_ticks(60);
    total_cnt++; if ({bus.rx_valid, bus.rx_orer, bus.rx_fer} !== 3'b001) $display("FAIL brk_after_rise: got %b want 001", {bus.rx_valid, bus.rx_orer, bus.rx_fer}); else pass_cnt++;
  endtask

  task automatic test_tx_a5();
    int n0;
    bit ok;
    logic b;
    bus.pe = 1'b1; bus.oe = 1'b0; bus.stop = 1'b0;
    push_tx_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    offer(8'hA5);
    wait_tx_start(n0, ok);
    total_cnt++; if (!ok) $display("FAIL tx_a5_start: got no start want start"); else pass_cnt++;
    total_cnt++; if (bus.tx_ready !== 1'b1) $display("FAIL tx_a5_ready: got %b want 1", bus.tx_ready); else pass_cnt++;
    for (int i = 0; i < 11; i++) begin
      wait_until(n0 + 16 * i + 8);
      b = txq.pop_front();
      total_cnt++; if (bus.txd_out !== b) $display("FAIL tx_a5_bit%0d: got %b want %b", i, bus.txd_out, b); else pass_cnt++;
    end
    wait_until(n0 + 175);
    total_cnt++; if (bus.tx_busy !== 1'b1) $display("FAIL tx_a5_busy_175: got %b want 1", bus.tx_busy); else pass_cnt++;
    wait_until(n0 + 176);
    total_cnt++; if ({bus.tx_busy, bus.txd_out} !== 2'b01) $display("FAIL tx_a5_idle_176: got %b want 01", {bus.tx_busy, bus.txd_out}); else pass_cnt++;
    bus.pe = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n0;
    bit ok;
    logic b;
    bus.pe = 1'b0; bus.stop = 1'b1;
    push_tx_frame(8'h55, 1'b0, 1'b0, 1'b1);
    push_tx_frame(8'hAA, 1'b0, 1'b0, 1'b1);
    offer(8'h55);
    wait_tx_start(n0, ok);
    total_cnt++; if (!ok || bus.tx_ready !== 1'b1) $display("FAIL b2b_first_start: got ok=%b ready=%b want 1 1", ok, bus.tx_ready); else pass_cnt++;
    offer(8'hAA);
    total_cnt++; if (bus.tx_ready !== 1'b0) $display("FAIL b2b_hold_full: got %b want 0", bus.tx_ready); else pass_cnt++;
    for (int i = 0; i < 11; i++) begin
      wait_until(n0 + 16 * i + 8);
      b = txq.pop_front();
      total_cnt++; if (bus.txd_out !== b) $display("FAIL b2b_f1_bit%0d: got %b want %b", i, bus.txd_out, b); else pass_cnt++;
    end
    wait_until(n0 + 176);
    total_cnt++; if ({bus.txd_out, bus.tx_ready, bus.tx_busy} !== 3'b011) $display("FAIL b2b_second_start: got %b want 011", {bus.txd_out, bus.tx_ready, bus.tx_busy}); else pass_cnt++;
    for (int i = 11; i < 22; i++) begin
      wait_until(n0 + 16 * i + 8);
      b = txq.pop_front();
      total_cnt++; if (bus.txd_out !== b) $display("FAIL b2b_f2_bit%0d: got %b want %b", i - 11, bus.txd_out, b); else pass_cnt++;
    end
    wait_until(n0 + 352);
    total_cnt++; if (bus.tx_busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", bus.tx_busy); else pass_cnt++;
    bus.stop = 1'b0;
  endtask

  task automatic test_reset_mid_tx();
    int n0;
    int t;
    bit ok;
    bit seen_low;
    rx_exp_t e;
    rxq.push_back('{8'h81, 1'b0, 1'b0});
    send_frame(8'h81, 1'b0, 1'b0);
    e = rxq.pop_front();
    total_cnt++; if (bus.rx_data !== e.d || bus.rx_valid !== 1'b1) $display("FAIL rst_pre_rx: got %h/%b want %h/1", bus.rx_data, bus.rx_valid, e.d); else pass_cnt++;
    offer(8'hF0);
    wait_tx_start(n0, ok);
    wait_until(n0 + 40);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++; if ({bus.txd_out, bus.tx_ready, bus.tx_busy, bus.rx_valid} !== 4'b1100) $display("FAIL rst_mid_state: got %b want 1100", {bus.txd_out, bus.tx_ready, bus.tx_busy, bus.rx_valid}); else pass_cnt++;
    seen_low = 1'b0;
    t = tick_no + 300;
    while (tick_no < t) begin
      @(negedge clk);
      if (bus.txd_out !== 1'b1 || bus.tx_busy !== 1'b0) seen_low = 1'b1;
    end
    total_cnt++; if (seen_low) $display("FAIL rst_mid_quiet: got line activity want none"); else pass_cnt++;
  endtask

  initial begin
    bus.ce       = 1'b1;
    bus.pe       = 1'b0;
    bus.oe       = 1'b0;
    bus.stop     = 1'b0;
    bus.rxd_in   = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ack   = 1'b0;
    @(negedge clk);
    test_reset();
    test_rx_basic();
    test_rx_parity();
    test_glitch();
    test_overrun();
    test_ack_at_load();
    test_break();
    test_tx_a5();
    test_back_to_back();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
